// File: rtl/muller_c_pkg.sv
// Shared types and defaults for the Muller C-element scheduler.
package muller_c_pkg;

  // Controller states; FLUSH is the reset state.
  typedef enum logic [2:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam int SYNC_STAGES_DEF    = 2;
  localparam int TIMEOUT_CYCLES_DEF = 15;

endpackage

// File: rtl/muller_c_sync.sv
// Multi-flop synchronizer for the asynchronous C-element output.
module muller_c_sync
  import muller_c_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] chain;

  // Shift the raw input through the flop chain; the chain clears on reset.
  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[SYNC_STAGES-2:0], async_in};
  end

  assign sync_out = chain[SYNC_STAGES-1];

endmodule

// File: rtl/muller_c_sched.sv
// Round-robin scheduler sharing one Muller C-element between clocked requesters.
//
// Handshake: requester i transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high. req_ready is only ever one-hot and only in IDLE;
// req_a/req_b are sampled on that transfer edge and nowhere else. rsp_valid is
// a one-cycle strobe with no back-pressure; rsp_id/rsp_c/rsp_timeout are valid
// while it is high.
module muller_c_sched
  import muller_c_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = 4,
  parameter int ID_W           = 2
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_a,
  input  logic [NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0] req_ready,
  output logic               rsp_valid,
  output logic [ID_W-1:0]    rsp_id,
  output logic               rsp_c,
  output logic               rsp_timeout,
  output logic               c_a,
  output logic               c_b,
  input  logic               c_y,
  output logic               busy
);

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   op_id;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              sync_y;
  logic              grant_found;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   ptr_next;
  logic [ID_W:0]     cand_sum;
  logic [ID_W-1:0]   cand;

  muller_c_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .async_in(c_y),
    .sync_out(sync_y)
  );

  // Round-robin pick: first valid index at or after the pointer, wrapping; IDLE only.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand_sum    = '0;
    cand        = '0;
    if (state == ST_IDLE) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand_sum = {1'b0, ptr} + (ID_W+1)'(i);
        if (cand_sum >= (ID_W+1)'(NUM_REQ)) cand_sum = cand_sum - (ID_W+1)'(NUM_REQ);
        cand = cand_sum[ID_W-1:0];
        if (!grant_found && req_valid[cand]) begin
          grant_found = 1'b1;
          grant_id    = cand;
        end
      end
    end
  end

  // One-hot grant derived from the pick.
  always_comb begin
    req_ready = '0;
    if (grant_found) req_ready[grant_id] = 1'b1;
  end

  assign ptr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
  // Counter value including the current cycle, so a compare hits on the Nth cycle.
  assign cnt_inc  = cnt + CNT_W'(1);
  assign busy     = (state != ST_IDLE);

  // Controller: flush, arbitrate, drive the element, wait for settle/timeout, respond.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= ST_FLUSH;
      c_a         <= 1'b0;
      c_b         <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_c       <= 1'b0;
      rsp_id      <= '0;
      ptr         <= '0;
      op_id       <= '0;
      cnt         <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_FLUSH: begin
          c_a <= 1'b0;
          c_b <= 1'b0;
          cnt <= cnt_inc;
          if (!sync_y || cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        end
        ST_IDLE: begin
          if (grant_found) begin
            // Operands go straight into the drive flops so the element sees
            // them the cycle after transfer; c_a/c_b double as the latched a/b.
            c_a   <= req_a[grant_id];
            c_b   <= req_b[grant_id];
            op_id <= grant_id;
            ptr   <= ptr_next;
            state <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt <= cnt_inc;
          if (c_a == c_b) begin
            if (sync_y == c_a) begin
              state       <= ST_RESP;
              rsp_valid   <= 1'b1;
              rsp_c       <= sync_y;
              rsp_timeout <= 1'b0;
              rsp_id      <= op_id;
            end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
              state       <= ST_RESP;
              rsp_valid   <= 1'b1;
              rsp_c       <= sync_y;
              rsp_timeout <= 1'b1;
              rsp_id      <= op_id;
            end
          end else if (cnt_inc == CNT_W'(SYNC_STAGES)) begin
            // Hold case: element keeps its value; wait only for the synchronizer.
            state       <= ST_RESP;
            rsp_valid   <= 1'b1;
            rsp_c       <= sync_y;
            rsp_timeout <= 1'b0;
            rsp_id      <= op_id;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_FLUSH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muller_c_sched.sv
// Scoreboard bench for muller_c_sched with a behavioural C-element and reference model.
module tb_muller_c_sched;

  localparam int N   = 4;
  localparam int SS  = 2;
  localparam int TO  = 15;

  logic         wb_clk_i;
  logic         wb_rst_i;
  logic [3:0]   req_valid;
  logic [3:0]   req_a;
  logic [3:0]   req_b;
  logic [3:0]   req_ready;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic         rsp_c;
  logic         rsp_timeout;
  logic         c_a;
  logic         c_b;
  logic         c_y;
  logic         busy;

  // Element model state, stuck-at-0 fault injection on its output.
  logic         y_state;
  logic         stuck0;

  int           cyc = 0;
  int           total = 0;
  int           bad = 0;
  // Entry: {due cycle[31:0], id[1:0], c, timeout}
  logic [35:0]  exp_q[$];
  logic [35:0]  e;
  int           model_ptr;
  logic         model_elem;

  muller_c_sched #(
    .NUM_REQ(N), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO), .CNT_W(4), .ID_W(2)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_c      (rsp_c),
    .rsp_timeout(rsp_timeout),
    .c_a        (c_a),
    .c_b        (c_b),
    .c_y        (c_y),
    .busy       (busy)
  );

  // Clock / cycle counter
  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  // Zero-delay C-element: follows inputs when they agree, otherwise holds.
  always @(c_a or c_b or wb_rst_i) begin
    if (!wb_rst_i && c_a == c_b) y_state = c_a;
  end
  assign c_y = stuck0 ? 1'b0 : y_state;

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver: present one request set, wait for the grant, predict the response.
  task automatic do_op(input logic [3:0] mask, input logic [3:0] av, input logic [3:0] bv,
                       input bit push);
    bit         got;
    logic [1:0] gid;
    logic       a;
    logic       b;
    logic       ec;
    logic       eto;
    int         lat;
    @(negedge wb_clk_i);
    req_valid = mask;
    req_a     = av;
    req_b     = bv;
    got       = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      #1;
      if ((req_ready & req_valid) != 4'b0) got = 1'b1;
      else @(negedge wb_clk_i);
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL grant_wait: no grant for mask %b, want one within 100 cycles", mask);
      req_valid = '0;
      return;
    end
    // First requesting index at or after the model pointer wins.
    gid = 2'd0;
    for (int i = N - 1; i >= 0; i--) begin
      int idx;
      idx = (model_ptr + i) % N;
      if (((mask >> idx) & 4'b0001) != 4'b0) gid = 2'(idx);
    end
    check1("grant_onehot", 32'(req_ready), 32'(4'b0001 << gid));
    a = av[gid];
    b = bv[gid];
    if (a == b) begin
      if (stuck0 && a) begin
        ec = 1'b0; eto = 1'b1; lat = TO + 2;
      end else begin
        ec = a; eto = 1'b0;
        lat = (model_elem == a) ? 3 : SS + 2;
      end
      model_elem = a;
    end else begin
      ec = model_elem; eto = 1'b0; lat = SS + 2;
    end
    model_ptr = (int'(gid) + 1) % N;
    if (push) exp_q.push_back({32'(cyc + lat), gid, ec, eto});
    @(posedge wb_clk_i);
    #1;
    req_valid = '0;
    @(negedge wb_clk_i);
    check1("c_a_drive", 32'(c_a), 32'(a));
    check1("c_b_drive", 32'(c_b), 32'(b));
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge wb_clk_i);
      if (exp_q.size() == 0 && !busy) ok = 1'b1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL idle_wait: busy=%0d pending=%0d, want 0/0", busy, exp_q.size());
    end
  endtask

  // Monitor: pop and compare on every response strobe.
  initial begin
    forever begin
      @(negedge wb_clk_i);
      if (rsp_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rsp_unexpected: id=%0d c=%0d to=%0d cycle=%0d, want no response",
                   rsp_id, rsp_c, rsp_timeout, cyc);
        end else begin
          e = exp_q.pop_front();
          if (rsp_id !== e[3:2] || rsp_c !== e[1] || rsp_timeout !== e[0] || cyc != int'(e[35:4])) begin
            bad++;
            $display("FAIL rsp: got id=%0d c=%0d to=%0d cycle=%0d, want id=%0d c=%0d to=%0d cycle=%0d",
                     rsp_id, rsp_c, rsp_timeout, cyc, e[3:2], e[1], e[0], int'(e[35:4]));
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // Stimulus sequence
  initial begin
    logic [3:0] m;
    logic [3:0] av;
    logic [3:0] bv;
    bit         idle_seen;
    stuck0     = 1'b0;
    y_state    = 1'b1;
    wb_rst_i   = 1'b1;
    req_valid  = 4'hF;
    req_a      = '0;
    req_b      = '0;
    model_ptr  = 0;
    model_elem = 1'b0;

    // Reset state
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check1("rst_c_a", 32'(c_a), 0);
    check1("rst_c_b", 32'(c_b), 0);
    check1("rst_busy", 32'(busy), 1);
    check1("rst_ready", 32'(req_ready), 0);
    check1("rst_rsp_valid", 32'(rsp_valid), 0);
    check1("rst_rsp_timeout", 32'(rsp_timeout), 0);
    check1("rst_rsp_c", 32'(rsp_c), 0);
    check1("rst_rsp_id", 32'(rsp_id), 0);
    req_valid = '0;
    wb_rst_i  = 1'b0;

    // Flush exits to IDLE once the element reads back 0
    idle_seen = 1'b0;
    for (int k = 0; k < 20 && !idle_seen; k++) begin
      @(negedge wb_clk_i);
      if (!busy) idle_seen = 1'b1;
    end
    check1("flush_exit", 32'(idle_seen), 1);
    check1("flush_c_a", 32'(c_a), 0);

    // Single op and hold case
    do_op(4'b0001, 4'b0001, 4'b0001, 1'b1);
    wait_idle();
    do_op(4'b0100, 4'b0100, 4'b0000, 1'b1);
    wait_idle();

    // Round-robin with all requesters held, a==b alternating
    for (int k = 0; k < 5; k++) begin
      av = (k % 2 == 1) ? 4'hF : 4'h0;
      do_op(4'hF, av, av, 1'b1);
    end
    wait_idle();

    // Timeout with the element stuck at 0, then a normal op
    stuck0 = 1'b1;
    do_op(4'b1000, 4'hF, 4'hF, 1'b1);
    wait_idle();
    stuck0 = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    do_op(4'b0010, 4'h0, 4'h0, 1'b1);
    wait_idle();

    // Randomized traffic
    for (int k = 0; k < 20; k++) begin
      m  = 4'($urandom_range(1, 15));
      av = 4'($urandom_range(0, 15));
      bv = ($urandom_range(0, 1) == 1) ? av : 4'($urandom_range(0, 15));
      do_op(m, av, bv, 1'b1);
    end
    wait_idle();

    // Reset in the middle of WAIT drops the operation
    stuck0 = 1'b1;
    do_op(4'b0010, 4'hF, 4'hF, 1'b0);
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    check1("midrst_c_a", 32'(c_a), 0);
    check1("midrst_c_b", 32'(c_b), 0);
    check1("midrst_busy", 32'(busy), 1);
    check1("midrst_rsp_valid", 32'(rsp_valid), 0);
    @(negedge wb_clk_i);
    wb_rst_i   = 1'b0;
    stuck0     = 1'b0;
    model_ptr  = 0;
    model_elem = 1'b0;
    wait_idle();
    repeat (3) @(negedge wb_clk_i);
    do_op(4'hF, 4'hF, 4'hF, 1'b1);
    wait_idle();

    check1("queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
